// File: rtl/jt12_pg_ctrl_pkg.sv
// Shared constants for the phase-generator control block.
// Holds slot/channel counts, write-select codes and operator order.
package jt12_pg_ctrl_pkg;

   localparam int NUM_SLOTS = 24;
   localparam int NUM_CH    = 6;

   localparam logic [1:0] SEL_FNUM = 2'd0;
   localparam logic [1:0] SEL_MUL  = 2'd1;
   localparam logic [1:0] SEL_KEY  = 2'd2;
   localparam logic [1:0] SEL_RSVD = 2'd3;

   // Enum value is the bit position inside the key mask (S4..S1).
   typedef enum logic [1:0] {
      OP_S1 = 2'd0,
      OP_S2 = 2'd1,
      OP_S3 = 2'd2,
      OP_S4 = 2'd3
   } op_e;

   // Operator served by slot group s div 6.
   localparam op_e OP_ORDER [4] = '{OP_S1, OP_S3, OP_S2, OP_S4};

   function automatic logic [2:0] chan_of(input logic [4:0] s);
      return 3'(s % 5'd6);
   endfunction

endpackage

// File: rtl/jt12_sh.sv
// Plain shift register used for stage alignment delays.
// Ports: clk, rst_n (sync, active-low), clk_en, din in; drop out.
module jt12_sh #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] drop
);

   logic [STAGES-1:0][WIDTH-1:0] bits;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bits <= '0;
      end else if (clk_en) begin
         bits[0] <= din;
         for (int i = 1; i < STAGES; i++)
            bits[i] <= bits[i-1];
      end
   end

   assign drop = bits[STAGES-1];

endmodule

// File: rtl/jt12_pg_ctrl.sv
// Phase-generator control: slot sequencing, register file, key-on, phase clear.
// In: clk, rst_n, wr_en/wr_sel/wr_addr/wr_data, pg_rst_in.
// Out: fnum_I, block_I, dt1_II, mul_V, keyon_II, pg_rst, zero, slot_I.
module jt12_pg_ctrl
   import jt12_pg_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [1:0]  wr_sel,
   input  logic [4:0]  wr_addr,
   input  logic [13:0] wr_data,
   input  logic        pg_rst_in,
   output logic [10:0] fnum_I,
   output logic [2:0]  block_I,
   output logic [2:0]  dt1_II,
   output logic [3:0]  mul_V,
   output logic        keyon_II,
   output logic        pg_rst,
   output logic        zero,
   output logic [4:0]  slot_I
);

   logic [4:0]                   slot;
   logic [4:0]                   slot_nx;
   logic                         last;
   logic [NUM_CH-1:0][13:0]      ch_mem;
   logic [NUM_SLOTS-1:0][6:0]    sl_mem;
   logic [NUM_SLOTS-1:0]         mask;
   logic [NUM_SLOTS-1:0]         armed;
   logic [NUM_SLOTS-1:0]         mask_nx;
   logic [NUM_SLOTS-1:0]         armed_nx;
   logic [13:0]                  ch_rd;
   logic [2:0]                   dt1_q;
   logic [3:0]                   mul_q;
   logic                         keyon_q;
   logic                         pg_q;
   logic                         pend;
   logic                         wr_ch;
   logic                         wr_sl;
   logic                         wr_key;
   logic [3:0]                   key_bits;
   logic [4:0]                   ks;

   assign last    = (slot == 5'(NUM_SLOTS - 1));
   assign slot_nx = last ? 5'd0 : slot + 5'd1;
   assign key_bits = wr_data[3:0];

   always_comb begin
      wr_ch  = 1'b0;
      wr_sl  = 1'b0;
      wr_key = 1'b0;
      if (wr_en) begin
         case (wr_sel)
            SEL_FNUM: wr_ch  = (wr_addr < 5'(NUM_CH));
            SEL_MUL:  wr_sl  = (wr_addr < 5'(NUM_SLOTS));
            SEL_KEY:  wr_key = (wr_addr < 5'(NUM_CH));
            SEL_RSVD: ;
         endcase
      end
   end

   // The stage-I slot consumes its armed bit; a mask write then
   // re-arms only on a 0->1 edge and cancels on 0.
   always_comb begin
      mask_nx  = mask;
      armed_nx = armed;
      ks       = '0;
      armed_nx[slot] = 1'b0;
      if (wr_key) begin
         for (int i = 0; i < 4; i++) begin
            ks = wr_addr + 5'(NUM_CH * i);
            mask_nx[ks]  = key_bits[OP_ORDER[i]];
            armed_nx[ks] = key_bits[OP_ORDER[i]]
                         & (~mask[ks] | armed_nx[ks]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot    <= '0;
         ch_mem  <= '0;
         sl_mem  <= '0;
         mask    <= '0;
         armed   <= '0;
         ch_rd   <= '0;
         dt1_q   <= '0;
         mul_q   <= '0;
         keyon_q <= 1'b0;
         pg_q    <= 1'b0;
         pend    <= 1'b0;
      end else begin
         slot    <= slot_nx;
         ch_rd   <= ch_mem[chan_of(slot_nx)];
         dt1_q   <= sl_mem[slot][6:4];
         mul_q   <= sl_mem[slot][3:0];
         keyon_q <= armed[slot];
         mask    <= mask_nx;
         armed   <= armed_nx;
         if (wr_ch)
            ch_mem[wr_addr[2:0]] <= wr_data;
         if (wr_sl)
            sl_mem[wr_addr] <= wr_data[6:0];
         // Requests inside an active window are dropped.
         if (pg_q) begin
            if (last)
               pg_q <= 1'b0;
         end else if (last && (pend || pg_rst_in)) begin
            pg_q <= 1'b1;
            pend <= 1'b0;
         end else begin
            pend <= pend | pg_rst_in;
         end
      end
   end

   // mul_q sits in stage II; three more stages reach stage V.
   jt12_sh #(.WIDTH(4), .STAGES(3)) u_mul_sh (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (1'b1),
      .din    (mul_q),
      .drop   (mul_V)
   );

   assign fnum_I   = ch_rd[10:0];
   assign block_I  = ch_rd[13:11];
   assign dt1_II   = dt1_q;
   assign keyon_II = keyon_q;
   assign pg_rst   = pg_q;
   assign zero     = (slot == 5'd0);
   assign slot_I   = slot;

endmodule

// File: doc/jt12_pg_ctrl.md
JT12_PG_CTRL -- requirements
Module: jt12_pg_ctrl

Interface
REQ-001 Parameters: none; slot count 24 and channel count 6 are fixed constants.
REQ-002 clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 wr_en  in  1  write strobe, one write per cycle.
REQ-005 wr_sel  in  2  0=fnum/block (per channel), 1=mul/dt1 (per slot), 2=key mask (per channel), 3=reserved (ignored).
REQ-006 wr_addr  in  5  channel 0..5 (sel 0/2) or slot 0..23 (sel 1).
REQ-007 wr_data  in  14  sel0: [13:11] block, [10:0] fnum; sel1: [6:4] dt1, [3:0] mul; sel2: [3:0] operator mask, S4..S1.
REQ-008 pg_rst_in  in  1  global phase clear request.
REQ-009 fnum_I  out  11  fnum of the slot in stage I.
REQ-010 block_I  out  3  block of the slot in stage I.
REQ-011 dt1_II  out  3  dt1 of the slot in stage II.
REQ-012 mul_V  out  4  mul of the slot in stage V.
REQ-013 keyon_II  out  1  key-on rising-edge pulse for the slot in stage II.
REQ-014 pg_rst  out  1  phase clear, held for one full 24-slot round.
REQ-015 zero  out  1  high while the stage-I slot is 0.
REQ-016 slot_I  out  5  stage-I slot index, for debug.

Function
REQ-017 Slot counter advances by 1 every cycle, wraps 23->0; slot s maps to channel s mod 6 and operator index s div 6, operator order S1,S3,S2,S4.
REQ-018 fnum_I/block_I SHALL show the channel registers for slot_I in the same cycle, registered read (read address = next slot).
REQ-019 dt1_II SHALL equal the dt1 of slot (slot_I-1) mod 24; mul_V of slot (slot_I-4) mod 24; keyon_II relates to slot (slot_I-1) mod 24.
REQ-020 Writes take effect from the cycle after wr_en; if a write hits the entry being read that cycle, the output shows the old value.
REQ-021 Out-of-range addresses (channel >5, slot >23) and wr_sel=3 SHALL be ignored without side effects.
REQ-022 Per-operator key state: a mask bit going 0->1 arms that operator; keyon_II pulses high for exactly one cycle on that operator's next stage-II occurrence, then disarms.
REQ-023 Mask bit 1->0 before the pulse is delivered cancels the pending pulse; re-writing 1 over 1 arms nothing.
REQ-024 pg_rst_in sampled high: pg_rst asserts from the next slot-0 stage-I cycle for exactly 24 cycles; a further request during that window does not extend it.
REQ-025 zero SHALL pulse once every 24 cycles, aligned with slot_I=0.

Reset
REQ-026 While rst_n=0: slot counter=0, all fnum/block/mul/dt1/mask/key-state registers=0, pending key-ons cleared, delay lines cleared.
REQ-027 Outputs during reset and first cycle after: fnum_I=0, block_I=0, dt1_II=0, mul_V=0, keyon_II=0, pg_rst=0, zero=1, slot_I=0.
REQ-028 Reset mid-round SHALL abandon the round; first post-reset cycle is slot 0; writes during reset are discarded.

Structure
REQ-029 Shared package holds NUM_SLOTS=24, NUM_CH=6, the wr_sel codes and the operator-order table.
REQ-030 Stage alignment delays use the existing jt12_sh shift register; no other sub-module.
REQ-031 Channel storage 6x14 bits, slot storage 24x7 bits, key storage 24x2 bits (mask, armed); flops or inferred RAM.

Verification
REQ-032 Reset release -> zero high at cycles 0, 24, 48; slot_I counts 0..23 and wraps.
REQ-033 Write sel0 ch2 data {3'd4,11'h2A5} -> fnum_I=0x2A5, block_I=4 at slot_I=2,8,14,20 only.
REQ-034 Write sel1 slot7 {dt1=5,mul=9} -> dt1_II=5 when slot_I=8, mul_V=9 when slot_I=11.
REQ-035 Write sel2 ch1 mask 4'b0101 -> keyon_II single pulses for slots 1 (S1) and 7 (S3) on the next pass only; rewrite 0101 -> no pulse.
REQ-036 pg_rst_in pulse at slot 10 -> pg_rst high for slot_I 0..23 of the next round, second request at slot 5 ignored.
REQ-037 Reset at slot 13 with pending key-on -> no keyon_II after release, slot_I restarts 0, registers read 0.
